wb_arbiter: RTL and testbench

Shares the single register-file write port of the 16-bit MIPS pipeline between the ALU result path and the data-memory load path, the two producers that feed the write-back stage. The block runs a round-robin arbiter with valid/ready handshakes on both sources and a one-entry registered output toward the register file. Writes to register 0 are suppressed. A saturating counter of committed writes is kept for debug.

---
 rtl/wb_arbiter_if.sv | 53 +++++
 rtl/wb_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bundle for the write-back arbiter's ports: the ALU and load sources,
// the register-file write port and the debug counter.
//
// Ports carried:
//   alu_valid/alu_waddr/alu_wdata  ALU request in, alu_ready back
//   dm_valid/dm_waddr/dm_wdata     load request in, dm_ready back
//   rf_stall                       register file not sampling this cycle
//   rf_we/rf_waddr/rf_wdata        registered write port toward the register file
//   wr_count                       saturating count of committed writes
//
// Modports:
//   master  environment side (drives requests and rf_stall)
//   slave   arbiter side (drives readies and the write port)
interface wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              alu_ready;

  logic              dm_valid;
  logic [ADDR_W-1:0] dm_waddr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;

  logic              rf_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [CNT_W-1:0]  wr_count;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output dm_valid, dm_waddr, dm_wdata,
    output rf_stall,
    input  alu_ready, dm_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  wr_count
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  dm_valid, dm_waddr, dm_wdata,
    input  rf_stall,
    output alu_ready, dm_ready,
    output rf_we, rf_waddr, rf_wdata,
    output wr_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between the
// ALU result path and the load path with a one-entry registered output.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    wb_arbiter_if.slave (source handshakes, rf write port, wr_count)
//
// Arbitration is round-robin on ties. Defining WB_DM_PRIORITY_EN
// switches to fixed priority where the load source always wins a tie.
// Writes to register 0 complete the handshake but never assert rf_we.
module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_DM  = 1'b1
  } grant_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  grant_e            last_q;
  grant_e            last_d;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              commit;
  logic              accept_ok;
  logic              gnt_alu;
  logic              gnt_dm;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // The output slot can take a new entry when it is empty or when the
  // register file is draining it on this same edge.
  assign commit    = we_q & ~bus.rf_stall;
  assign accept_ok = ~bus.rf_stall | ~we_q;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_dm  = 1'b0;
    if (!reset && accept_ok) begin
      unique case ({bus.alu_valid, bus.dm_valid})
        2'b10: gnt_alu = 1'b1;
        2'b01: gnt_dm  = 1'b1;
        2'b11: begin
`ifdef WB_DM_PRIORITY_EN
          gnt_dm = 1'b1;
`else
          if (last_q == LAST_DM) begin
            gnt_alu = 1'b1;
          end else begin
            gnt_dm = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign xfer     = gnt_alu | gnt_dm;
  assign sel_addr = gnt_dm ? bus.dm_waddr : bus.alu_waddr;
  assign sel_data = gnt_dm ? bus.dm_wdata : bus.alu_wdata;

  always_comb begin
    last_d = last_q;
    if (gnt_alu) begin
      last_d = LAST_ALU;
    end else if (gnt_dm) begin
      last_d = LAST_DM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= LAST_DM;
    end else begin
      last_q <= last_d;
    end
  end

  // Address/data load on every transfer, even to register 0, so the
  // port reflects the last accepted request; only rf_we is suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (xfer) begin
      we_q    <= (sel_addr != '0);
      waddr_q <= sel_addr;
      wdata_q <= sel_data;
    end else if (!bus.rf_stall) begin
      we_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (commit && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.alu_ready = gnt_alu;
  assign bus.dm_ready  = gnt_dm;
  assign bus.rf_we     = we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.wr_count  = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level model of the write port.
module tb_wb_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;
`ifdef WB_DM_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) bus ();
  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4))  sbus ();

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .bus(sbus.slave)
  );

  assign sbus.alu_valid = bus.alu_valid;
  assign sbus.alu_waddr = bus.alu_waddr;
  assign sbus.alu_wdata = bus.alu_wdata;
  assign sbus.dm_valid  = bus.dm_valid;
  assign sbus.dm_waddr  = bus.dm_waddr;
  assign sbus.dm_wdata  = bus.dm_wdata;
  assign sbus.rf_stall  = bus.rf_stall;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one pending output slot, who won the last tie, commit count.
  bit          m_full    = 1'b0;
  bit          m_last_dm = 1'b1;
  bit          x_alu     = 1'b0;
  bit          x_dm      = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  int          m_cnt     = 0;

  function automatic void grant(output bit ga, output bit gd);
    bit a;
    bit d;
    a  = bus.alu_valid;
    d  = bus.dm_valid;
    ga = 1'b0;
    gd = 1'b0;
    if (reset || (m_full && bus.rf_stall)) return;
    if (a && d) begin
      if (PRIO || !m_last_dm) gd = 1'b1;
      else ga = 1'b1;
    end else begin
      ga = a;
      gd = d;
    end
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit ga;
    bit gd;
    logic [AW-1:0] na;
    if (reset) begin
      m_full    <= 1'b0;
      m_last_dm <= 1'b1;
      m_addr    <= '0;
      m_data    <= '0;
      m_cnt     <= 0;
      x_alu     <= 1'b0;
      x_dm      <= 1'b0;
    end else begin
      grant(ga, gd);
      if (m_full && !bus.rf_stall) m_cnt <= m_cnt + 1;
      if (ga || gd) begin
        na = ga ? bus.alu_waddr : bus.dm_waddr;
        m_addr    <= na;
        m_data    <= ga ? bus.alu_wdata : bus.dm_wdata;
        m_full    <= (na != '0);
        m_last_dm <= gd;
      end else if (!bus.rf_stall) begin
        m_full <= 1'b0;
      end
      x_alu <= ga;
      x_dm  <= gd;
    end
  end

  always @(negedge clk) begin : compare
    bit ga;
    bit gd;
    int ec;
    int es;
    grant(ga, gd);
    ec = (m_cnt > 65535) ? 65535 : m_cnt;
    es = (m_cnt > 15) ? 15 : m_cnt;
    chk("alu_ready", 32'(bus.alu_ready), 32'(ga));
    chk("dm_ready", 32'(bus.dm_ready), 32'(gd));
    chk("rf_we", 32'(bus.rf_we), 32'(m_full));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_addr));
    chk("rf_wdata", 32'(bus.rf_wdata), 32'(m_data));
    chk("wr_count", 32'(bus.wr_count), 32'(ec));
    chk("s_rf_we", 32'(sbus.rf_we), 32'(m_full));
    chk("s_ready", 32'({sbus.alu_ready, sbus.dm_ready}), 32'({ga, gd}));
    chk("s_wdata", 32'(sbus.rf_wdata), 32'(m_data));
    chk("s_wr_count", 32'(sbus.wr_count), 32'(es));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    bus.alu_valid = 1'b0;
    bus.dm_valid  = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  // Keep each request up until it is taken, then drop it.
  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (!bus.alu_valid && !bus.dm_valid) break;
      cyc();
      if (x_alu) bus.alu_valid = 1'b0;
      if (x_dm)  bus.dm_valid  = 1'b0;
    end
    chk("drain", 32'({bus.alu_valid, bus.dm_valid}), 32'(0));
  endtask

  initial begin
    reset = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_waddr = '0;
    bus.alu_wdata = '0;
    bus.dm_valid  = 1'b0;
    bus.dm_waddr  = '0;
    bus.dm_wdata  = '0;
    bus.rf_stall  = 1'b0;
    #1 reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;

    // Contention straight out of reset: ALU wins the first tie.
    bus.alu_valid = 1'b1;
    bus.alu_waddr = 3'd1;
    bus.alu_wdata = 16'h1111;
    bus.dm_valid  = 1'b1;
    bus.dm_waddr  = 3'd2;
    bus.dm_wdata  = 16'h3331;
    @(negedge clk);
    chk("cont_first_alu", 32'(bus.alu_ready), 32'(!PRIO));
    chk("cont_first_dm", 32'(bus.dm_ready), 32'(PRIO));
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("cont_data", 32'(bus.rf_wdata),
          (PRIO || (i % 2 == 1)) ? 32'h3331 : 32'h1111);
      chk("cont_we", 32'(bus.rf_we), 32'(1));
    end
    drain();

    // Single source from reset.
    cyc();
    pulse_reset();
    bus.alu_valid = 1'b1;
    bus.alu_waddr = 3'd3;
    bus.alu_wdata = 16'h0034;
    @(negedge clk);
    chk("single_ready", 32'(bus.alu_ready), 32'(1));
    cyc();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    chk("single_we", 32'(bus.rf_we), 32'(1));
    chk("single_addr", 32'(bus.rf_waddr), 32'(3));
    chk("single_data", 32'(bus.rf_wdata), 32'h0034);
    chk("single_cnt0", 32'(bus.wr_count), 32'(0));
    cyc();
    @(negedge clk);
    chk("single_cnt1", 32'(bus.wr_count), 32'(1));
    chk("single_we_off", 32'(bus.rf_we), 32'(0));

    // Register 0 write is accepted but not committed.
    bus.dm_valid = 1'b1;
    bus.dm_waddr = 3'd0;
    bus.dm_wdata = 16'hFFFF;
    @(negedge clk);
    chk("r0_ready", 32'(bus.dm_ready), 32'(1));
    cyc();
    bus.dm_valid = 1'b0;
    @(negedge clk);
    chk("r0_we", 32'(bus.rf_we), 32'(0));
    chk("r0_data", 32'(bus.rf_wdata), 32'hFFFF);
    cyc();
    @(negedge clk);
    chk("r0_cnt", 32'(bus.wr_count), 32'(1));

    // Stall with a full output slot.
    bus.alu_valid = 1'b1;
    bus.alu_waddr = 3'd5;
    bus.alu_wdata = 16'h00AA;
    cyc();
    bus.alu_waddr = 3'd6;
    bus.alu_wdata = 16'h0BBB;
    bus.rf_stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(bus.alu_ready), 32'(0));
      chk("stall_we", 32'(bus.rf_we), 32'(1));
      chk("stall_data", 32'(bus.rf_wdata), 32'h00AA);
      chk("stall_cnt", 32'(bus.wr_count), 32'(1));
      cyc();
    end
    bus.rf_stall = 1'b0;
    @(negedge clk);
    chk("unstall_ready", 32'(bus.alu_ready), 32'(1));
    cyc();
    bus.alu_waddr = 3'd7;
    bus.alu_wdata = 16'h0CCC;
    bus.rf_stall  = 1'b1;
    @(negedge clk);
    chk("unstall_data", 32'(bus.rf_wdata), 32'h0BBB);
    chk("unstall_cnt", 32'(bus.wr_count), 32'(2));

    // Asynchronous reset mid-cycle while holding a full entry.
    #2 reset = 1'b1;
    #1;
    chk("arst_we", 32'(bus.rf_we), 32'(0));
    chk("arst_addr", 32'(bus.rf_waddr), 32'(0));
    chk("arst_data", 32'(bus.rf_wdata), 32'(0));
    chk("arst_cnt", 32'(bus.wr_count), 32'(0));
    chk("arst_ready", 32'(bus.alu_ready), 32'(0));
    cyc();
    bus.alu_valid = 1'b0;
    bus.rf_stall  = 1'b0;
    reset = 1'b0;

    // 17 commits saturate the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_waddr = 3'(1 + i % 7);
      bus.alu_wdata = 16'(i);
      cyc();
    end
    bus.alu_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("sat_small", 32'(sbus.wr_count), 32'(15));
    chk("sat_main", 32'(bus.wr_count), 32'(17));

    // Random traffic, protocol-legal: requests held until taken.
    for (int n = 0; n < 3000; n++) begin
      if (!bus.alu_valid || x_alu) begin
        bus.alu_valid = ($urandom_range(0, 9) < 6);
        bus.alu_waddr = 3'($urandom_range(0, 7));
        bus.alu_wdata = 16'($urandom);
      end
      if (!bus.dm_valid || x_dm) begin
        bus.dm_valid = ($urandom_range(0, 9) < 6);
        bus.dm_waddr = 3'($urandom_range(0, 7));
        bus.dm_wdata = 16'($urandom);
      end
      bus.rf_stall = ($urandom_range(0, 9) < 3);
      cyc();
    end
    bus.rf_stall = 1'b0;
    drain();
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
